// File: rtl/counter48_snapshot_reader.sv
// counter48_snapshot_reader: presents a wide counter on a narrow read bus as coherent slices,
// and raises sticky threshold-crossing and wrap-around flags.
module counter48_snapshot_reader #(
  parameter int DATASIZE = 16,
  parameter int BUSWIDTH = 16,
  localparam int NSLICES = (DATASIZE + BUSWIDTH - 1) / BUSWIDTH,
  localparam int SELW = (NSLICES > 1) ? $clog2(NSLICES) : 1
) (
  input  logic                clk,
  input  logic                res,
  input  logic [DATASIZE-1:0] value,
  input  logic                read_en,
  input  logic [SELW-1:0]     slice_sel,
  output logic [BUSWIDTH-1:0] read_data,
  output logic                read_valid,
  output logic                read_stale,
  input  logic [DATASIZE-1:0] threshold,
  input  logic                thr_enable,
  output logic                thr_flag,
  output logic                wrap_flag,
  input  logic                flag_clear
);

  localparam int PADW = NSLICES * BUSWIDTH;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  logic [0:0]          state;
  logic [0:0]          state_next;
  logic [DATASIZE-1:0] shadow;
  logic [DATASIZE-1:0] prev_value;
  logic [PADW-1:0]     shadow_ext;
  logic [BUSWIDTH-1:0] data_next;
  logic                stale_next;
  logic                shadow_load;
  logic                thr_set;
  logic                wrap_set;

  // Zero-extending the shadow to whole slices pads the top slice above DATASIZE.
  assign shadow_ext = PADW'(shadow);

  always_comb begin
    data_next   = '0;
    stale_next  = 1'b0;
    state_next  = state;
    shadow_load = 1'b0;
    if (slice_sel == '0) begin
      data_next   = value[BUSWIDTH-1:0];
      shadow_load = 1'b1;
      state_next  = (NSLICES == 1) ? IDLE : HELD;
    end else if (int'(slice_sel) < NSLICES) begin
      data_next  = shadow_ext[int'(slice_sel)*BUSWIDTH +: BUSWIDTH];
      stale_next = (state == IDLE);
      if ((state == HELD) && (int'(slice_sel) == NSLICES - 1)) begin
        state_next = IDLE;
      end
    end else begin
      stale_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state      <= IDLE;
      shadow     <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
      read_stale <= 1'b0;
    end else begin
      read_valid <= read_en;
      read_stale <= read_en & stale_next;
      if (read_en) begin
        read_data <= data_next;
        state     <= state_next;
        if (shadow_load) begin
          shadow <= value;
        end
      end
    end
  end

  // A set condition overrides a simultaneous clear so no event is lost.
  assign thr_set  = thr_enable && (prev_value < threshold) && (value >= threshold);
  assign wrap_set = (prev_value == {DATASIZE{1'b1}}) && (value == '0);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      prev_value <= '0;
      thr_flag   <= 1'b0;
      wrap_flag  <= 1'b0;
    end else begin
      prev_value <= value;
      thr_flag   <= thr_set | (thr_flag & ~flag_clear);
      wrap_flag  <= wrap_set | (wrap_flag & ~flag_clear);
    end
  end

endmodule

// File: tb/tb_counter48_snapshot_reader.sv
// Scoreboard bench for counter48_snapshot_reader: a 48/16 instance with random and directed
// stimulus, plus a 20/16 instance for upper-slice zero padding.
module tb_counter48_snapshot_reader;

  localparam int NS = 3;

  typedef struct {
    logic [15:0] data;
    logic        stale;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        res;
  logic [47:0] value;
  logic [47:0] threshold;
  logic        read_en;
  logic [1:0]  slice_sel;
  logic        thr_enable;
  logic        flag_clear;
  logic [15:0] read_data;
  logic        read_valid;
  logic        read_stale;
  logic        thr_flag;
  logic        wrap_flag;

  logic [19:0] value2;
  logic        read_en2;
  logic [0:0]  slice_sel2;
  logic [15:0] read_data2;
  logic        read_valid2;
  logic        read_stale2;
  logic        thr_flag2;
  logic        wrap_flag2;

  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  exp_t q1[$];
  exp_t q2[$];

  // Reference state: the captured snapshot and whether a coherent sequence is open.
  logic [47:0] m_shadow;
  bit          m_armed;
  logic [19:0] m2_shadow;
  bit          m2_armed;
  logic [47:0] m_prev;
  logic        m_thr;
  logic        m_wrap;

  counter48_snapshot_reader #(.DATASIZE(48), .BUSWIDTH(16)) dut (
    .clk(clk), .res(res), .value(value), .read_en(read_en), .slice_sel(slice_sel),
    .read_data(read_data), .read_valid(read_valid), .read_stale(read_stale),
    .threshold(threshold), .thr_enable(thr_enable), .thr_flag(thr_flag),
    .wrap_flag(wrap_flag), .flag_clear(flag_clear)
  );

  counter48_snapshot_reader #(.DATASIZE(20), .BUSWIDTH(16)) dut2 (
    .clk(clk), .res(res), .value(value2), .read_en(read_en2), .slice_sel(slice_sel2),
    .read_data(read_data2), .read_valid(read_valid2), .read_stale(read_stale2),
    .threshold(20'hFFFFF), .thr_enable(1'b0), .thr_flag(thr_flag2),
    .wrap_flag(wrap_flag2), .flag_clear(1'b0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Called at a negedge: the read is sampled at the next posedge and answered right after it.
  task automatic apply_read(input int sel);
    exp_t e;
    read_en   = 1'b1;
    slice_sel = 2'(sel);
    e.due     = cycle + 1;
    e.stale   = 1'b0;
    if (sel == 0) begin
      e.data   = value[15:0];
      m_shadow = value;
      m_armed  = 1'b1;
    end else if (sel < NS) begin
      e.data  = 16'(m_shadow >> (sel * 16));
      e.stale = !m_armed;
      if (m_armed && sel == NS - 1) m_armed = 1'b0;
    end else begin
      e.data  = 16'h0;
      e.stale = 1'b1;
    end
    q1.push_back(e);
  endtask

  task automatic apply_read2(input int sel);
    exp_t e;
    read_en2   = 1'b1;
    slice_sel2 = 1'(sel);
    e.due      = cycle + 1;
    e.stale    = 1'b0;
    if (sel == 0) begin
      e.data    = value2[15:0];
      m2_shadow = value2;
      m2_armed  = 1'b1;
    end else begin
      e.data   = 16'(m2_shadow >> 16);
      e.stale  = !m2_armed;
      m2_armed = 1'b0;
    end
    q2.push_back(e);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    read_en  = 1'b0;
    read_en2 = 1'b0;
  endtask

  // Flag reference: crossing and wrap evaluated from the previous and current counter values.
  always @(posedge clk or posedge res) begin
    if (res) begin
      m_prev = '0;
      m_thr  = 1'b0;
      m_wrap = 1'b0;
    end else begin
      if (thr_enable && (m_prev < threshold) && (value >= threshold)) m_thr = 1'b1;
      else if (flag_clear) m_thr = 1'b0;
      if ((m_prev == 48'hFFFF_FFFF_FFFF) && (value == 48'h0)) m_wrap = 1'b1;
      else if (flag_clear) m_wrap = 1'b0;
      m_prev = value;
    end
  end

  always @(negedge clk) begin
    if (!res) begin
      check_output("thr_flag", thr_flag, m_thr);
      check_output("wrap_flag", wrap_flag, m_wrap);
    end
  end

  // Read monitors: every read_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!res) begin
      if (read_valid) begin
        if (q1.size() == 0) begin
          check_output("rd_spurious_valid", read_valid, 1'b0);
        end else begin
          e = q1.pop_front();
          check_output("rd_latency", cycle, e.due);
          check_output("rd_data", read_data, e.data);
          check_output("rd_stale", read_stale, e.stale);
        end
      end else if (q1.size() > 0 && q1[0].due <= cycle) begin
        e = q1.pop_front();
        check_output("rd_missing_valid", read_valid, 1'b1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!res) begin
      if (read_valid2) begin
        if (q2.size() == 0) begin
          check_output("rd2_spurious_valid", read_valid2, 1'b0);
        end else begin
          e = q2.pop_front();
          check_output("rd2_latency", cycle, e.due);
          check_output("rd2_data", read_data2, e.data);
          check_output("rd2_stale", read_stale2, e.stale);
        end
      end else if (q2.size() > 0 && q2[0].due <= cycle) begin
        e = q2.pop_front();
        check_output("rd2_missing_valid", read_valid2, 1'b1);
      end
    end
  end

  initial begin
    res = 1'b0; value = '0; threshold = '1; read_en = 1'b0; slice_sel = '0;
    thr_enable = 1'b0; flag_clear = 1'b0; value2 = '0; read_en2 = 1'b0; slice_sel2 = '0;
    m_shadow = '0; m_armed = 1'b0; m2_shadow = '0; m2_armed = 1'b0;
    #1 res = 1'b1;
    #1;
    check_output("reset_read_data", read_data, 16'h0);
    check_output("reset_read_valid", read_valid, 1'b0);
    check_output("reset_read_stale", read_stale, 1'b0);
    check_output("reset_thr_flag", thr_flag, 1'b0);
    check_output("reset_wrap_flag", wrap_flag, 1'b0);
    @(negedge clk);
    res = 1'b0;

    // Upper slice before any slice-0 read comes from the cleared shadow and is stale.
    @(negedge clk); value = 48'hABCD_0000_0001; apply_read(1);
    @(negedge clk); apply_read(2);
    idle_cycle();

    // Coherent read while the live value rolls over between slices; 20-bit padding alongside.
    @(negedge clk); value = 48'h0000_1234_FFFF; apply_read(0);
    value2 = 20'hF_0001; apply_read2(0);
    @(negedge clk); value = 48'h0000_1235_0000; apply_read(1);
    value2 = 20'h0_0002; apply_read2(1);
    @(negedge clk); apply_read(2); read_en2 = 1'b0;
    @(negedge clk); apply_read(3);
    @(negedge clk); apply_read(1);
    idle_cycle();

    // Threshold crossing, set-beats-clear, then clear alone.
    @(negedge clk); thr_enable = 1'b1; threshold = 48'd100; value = 48'd99; flag_clear = 1'b1;
    @(negedge clk); flag_clear = 1'b0; value = 48'd100;
    @(negedge clk); check_output("thr_cross", thr_flag, 1'b1); value = 48'd99;
    @(negedge clk); value = 48'd150; flag_clear = 1'b1;
    @(negedge clk); check_output("thr_set_wins", thr_flag, 1'b1); value = 48'd150;
    @(negedge clk); check_output("thr_cleared", thr_flag, 1'b0); flag_clear = 1'b0;

    // Wrap only from all-ones; a load from all-ones-minus-one or a narrower all-ones does not count.
    @(negedge clk); thr_enable = 1'b0; value = 48'hFFFF_FFFF_FFFF;
    @(negedge clk); value = 48'h0;
    @(negedge clk); check_output("wrap_set", wrap_flag, 1'b1);
    flag_clear = 1'b1; value = 48'hFFFF_FFFF_FFFE;
    @(negedge clk); flag_clear = 1'b0; value = 48'h0;
    @(negedge clk); check_output("wrap_load_no_set", wrap_flag, 1'b0); value = 48'hFFFF;
    @(negedge clk); value = 48'h0;
    @(negedge clk); check_output("wrap_narrow_no_set", wrap_flag, 1'b0);

    // Reset lands while a slice-1 response is on the bus; the snapshot is lost.
    @(negedge clk); value = 48'h0000_5678_9ABC; apply_read(0);
    @(negedge clk); apply_read(1);
    @(posedge clk); #2;
    res = 1'b1;
    #1;
    check_output("midreset_valid", read_valid, 1'b0);
    check_output("midreset_data", read_data, 16'h0);
    q1.delete(); q2.delete();
    m_shadow = '0; m_armed = 1'b0; m2_shadow = '0; m2_armed = 1'b0;
    read_en = 1'b0; read_en2 = 1'b0;
    @(negedge clk); res = 1'b0;
    @(negedge clk); apply_read(1);
    idle_cycle();

    // Randomized traffic: counting, loads, threshold approaches and wraps with random reads.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: value = value + 48'd1;
        4:          value = 48'({$urandom(), $urandom()});
        5:          value = threshold - 48'($urandom_range(0, 2));
        6:          value = threshold + 48'($urandom_range(0, 2));
        7:          value = 48'hFFFF_FFFF_FFFF;
        8:          value = 48'h0;
        default:    value = {32'h0, 16'($urandom())};
      endcase
      if ($urandom_range(0, 15) == 0) threshold = value + 48'($urandom_range(0, 3));
      thr_enable = ($urandom_range(0, 3) != 0);
      flag_clear = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 2) != 0) apply_read($urandom_range(0, 3));
      else read_en = 1'b0;
      value2 = ($urandom_range(0, 1) == 0) ? value2 + 20'd1 : 20'($urandom());
      if ($urandom_range(0, 1) != 0) apply_read2($urandom_range(0, 1));
      else read_en2 = 1'b0;
    end

    idle_cycle();
    flag_clear = 1'b0;
    repeat (3) @(negedge clk);
    check_output("drain_q1", q1.size(), 0);
    check_output("drain_q2", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
